key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/key_debounce.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: FSM state encodings,
// default timing parameters and a counter-width helper.
package key_debounce_pkg;

  // 20 ms of stable samples at 27 MHz, minus one.
  localparam int DEF_DEBOUNCE_CNT = 539_999;
  // Number of debounce periods held before a long-press event (1 s).
  localparam int DEF_LONG_TICKS   = 50;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int counter_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. Both flops load
// RST_VAL while rst is high so the output starts from a known level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: first stage captures the pin, second stage the first.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer with press, release and long-press events.
// Handshake: none; every event output is a registered single-cycle pulse
// that the consumer samples on the clock edge where it is high, with no
// back-pressure. key_level is a registered level (1 = debounced pressed).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_level,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic [1:0] dbg_state
);

  localparam int CW = counter_width(DEBOUNCE_CNT);
  localparam int TW = counter_width(LONG_TICKS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CNT);
  localparam logic [TW-1:0] TICK_MAX  = TW'(LONG_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(LONG_TICKS - 1);

  logic key_in_sync;
  logic key_sync;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // The pin idles high (released), so the synchronizer resets to 1.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_in_sync)
  );

  // Active-low pin: invert so key_sync = 1 means pressed.
  assign key_sync = ~key_in_sync;

  // Next-state logic: each wait state needs DEBOUNCE_CNT+1 consecutive
  // agreeing samples; any disagreeing sample drops back without an event.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tick_d    = tick_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_sync) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!key_sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          tick_d  = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!key_sync) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          // One debounce period elapsed while held; tick saturates so the
          // long event can only fire on the single transition into TICK_MAX.
          cnt_d = '0;
          if (tick_q != TICK_MAX) begin
            tick_d = tick_q + 1'b1;
            if (tick_q == TICK_LAST) long_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        if (key_sync) begin
          // Release bounce: resume the press, keeping the hold time so far.
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          tick_d    = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tick_d  = '0;
      end
    endcase
  end

  // FSM registers and registered event pulses; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tick_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign key_level   = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign dbg_state   = state_q;

endmodule
